// File: rtl/lane_tol_checker.sv
// Lane-tolerance write checker: compares each DUT write beat against the next
// queued reference beat, lane by lane, with beat/error counters and first-error capture.
`timescale 1ns/1ps
module lane_tol_checker #(
    parameter int unsigned LANE_W    = 8,
    parameter int unsigned LANES     = 16,
    parameter int unsigned EXP_DEPTH = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [LANE_W-1:0]       tol,
    input  logic                    wrap_mode,
    input  logic [CNT_W-1:0]        exp_total,
    input  logic                    exp_valid,
    input  logic [LANES*LANE_W-1:0] exp_data,
    output logic                    exp_ready,
    input  logic                    wt_en,
    input  logic [ADDR_W-1:0]       wt_addr,
    input  logic [LANES*LANE_W-1:0] wt_data,
    output logic                    mismatch,
    output logic [LANES-1:0]        mismatch_lanes,
    output logic [CNT_W-1:0]        check_count,
    output logic [CNT_W-1:0]        err_count,
    output logic [ADDR_W-1:0]       first_err_addr,
    output logic                    first_err_vld,
    output logic                    underflow,
    output logic                    done
);
    localparam int unsigned DATA_W = LANES * LANE_W;
    localparam int unsigned PTR_W  = $clog2(EXP_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(EXP_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [DATA_W-1:0]   mem_q [EXP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                exp_ready_q, exp_ready_d;
    logic                push, pop, beat_ok, fifo_empty;

    logic [LANE_W-1:0]   tol_q, tol_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [CNT_W-1:0]    issued_q, issued_d;

    logic                s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]   s1_ckt_q, s1_ckt_d;
    logic [DATA_W-1:0]   s1_exp_q, s1_exp_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;

    logic [LANES-1:0]    lane_fail;
    logic [LANE_W-1:0]   lane_ckt, lane_exp, diff_fwd, diff_bwd;
    logic [LANE_W:0]     lane_dist;

    logic                mismatch_q, mismatch_d;
    logic [LANES-1:0]    mismatch_lanes_q, mismatch_lanes_d;
    logic [CNT_W-1:0]    check_count_q, check_count_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic                first_err_vld_q, first_err_vld_d;
    logic                underflow_q, underflow_d;
    logic                done_q, done_d;

    // Expected-beat FIFO; a beat stops being accepted once exp_total beats were issued
    always_comb begin
        push       = exp_valid && exp_ready_q;
        fifo_empty = (fcnt_q == '0);
        beat_ok    = (state_q == ST_RUN) && wt_en &&
                     ((total_q == '0) || (issued_q < total_q));
        pop        = beat_ok && !fifo_empty;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
            2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
            default: fcnt_d = fcnt_q;
        endcase
        exp_ready_d = (fcnt_d != FIFO_FULL);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= exp_data;
        end
    end

    // Per-lane distance: saturating |a-b| or shortest modular distance
    always_comb begin
        lane_fail = '0;
        lane_ckt  = '0;
        lane_exp  = '0;
        diff_fwd  = '0;
        diff_bwd  = '0;
        lane_dist = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_ckt = s1_ckt_q[i*LANE_W +: LANE_W];
            lane_exp = s1_exp_q[i*LANE_W +: LANE_W];
            diff_fwd = lane_ckt - lane_exp;
            diff_bwd = lane_exp - lane_ckt;
            if (mode_q) begin
                lane_dist = {1'b0, (diff_fwd < diff_bwd) ? diff_fwd : diff_bwd};
            end else begin
                lane_dist = (lane_ckt >= lane_exp) ? {1'b0, diff_fwd} : {1'b0, diff_bwd};
            end
            lane_fail[i] = (lane_dist > {1'b0, tol_q});
        end
    end

    // Next-state, stage-1 capture and stage-2 result/counter logic
    always_comb begin
        state_d          = state_q;
        tol_d            = tol_q;
        mode_d           = mode_q;
        total_d          = total_q;
        issued_d         = issued_q;
        s1_vld_d         = pop;
        s1_ckt_d         = s1_ckt_q;
        s1_exp_d         = s1_exp_q;
        s1_addr_d        = s1_addr_q;
        mismatch_d       = 1'b0;
        mismatch_lanes_d = '0;
        check_count_d    = check_count_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_vld_d  = first_err_vld_q;
        underflow_d      = underflow_q;

        if (pop) begin
            s1_ckt_d  = wt_data;
            s1_exp_d  = mem_q[rd_ptr_q];
            s1_addr_d = wt_addr;
            if (issued_q != CNT_MAX) begin
                issued_d = issued_q + CNT_W'(1);
            end
        end

        if (beat_ok && fifo_empty) begin
            underflow_d = 1'b1;
        end

        if (s1_vld_q) begin
            mismatch_d       = |lane_fail;
            mismatch_lanes_d = lane_fail;
            if (check_count_q != CNT_MAX) begin
                check_count_d = check_count_q + CNT_W'(1);
            end
            if (|lane_fail) begin
                if (err_count_q != CNT_MAX) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                if (!first_err_vld_q) begin
                    first_err_vld_d  = 1'b1;
                    first_err_addr_d = s1_addr_q;
                end
            end
        end

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN: begin
                if ((total_q != '0) && (check_count_d == total_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // Start pulse wins: restart from any state, FIFO contents kept
        if (enable) begin
            state_d          = ST_RUN;
            tol_d            = tol;
            mode_d           = wrap_mode;
            total_d          = exp_total;
            issued_d         = '0;
            mismatch_d       = 1'b0;
            mismatch_lanes_d = '0;
            check_count_d    = '0;
            err_count_d      = '0;
            first_err_addr_d = '0;
            first_err_vld_d  = 1'b0;
            underflow_d      = 1'b0;
        end

        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fcnt_q           <= '0;
            exp_ready_q      <= 1'b1;
            tol_q            <= '0;
            mode_q           <= 1'b0;
            total_q          <= '0;
            issued_q         <= '0;
            s1_vld_q         <= 1'b0;
            s1_ckt_q         <= '0;
            s1_exp_q         <= '0;
            s1_addr_q        <= '0;
            mismatch_q       <= 1'b0;
            mismatch_lanes_q <= '0;
            check_count_q    <= '0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
            underflow_q      <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fcnt_q           <= fcnt_d;
            exp_ready_q      <= exp_ready_d;
            tol_q            <= tol_d;
            mode_q           <= mode_d;
            total_q          <= total_d;
            issued_q         <= issued_d;
            s1_vld_q         <= s1_vld_d;
            s1_ckt_q         <= s1_ckt_d;
            s1_exp_q         <= s1_exp_d;
            s1_addr_q        <= s1_addr_d;
            mismatch_q       <= mismatch_d;
            mismatch_lanes_q <= mismatch_lanes_d;
            check_count_q    <= check_count_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_vld_q  <= first_err_vld_d;
            underflow_q      <= underflow_d;
            done_q           <= done_d;
        end
    end

    assign exp_ready      = exp_ready_q;
    assign mismatch       = mismatch_q;
    assign mismatch_lanes = mismatch_lanes_q;
    assign check_count    = check_count_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_vld  = first_err_vld_q;
    assign underflow      = underflow_q;
    assign done           = done_q;

endmodule

// File: tb/tb_lane_tol_checker.sv
// Bench for lane_tol_checker: directed scenarios and a random phase, each cycle
// compared against a queue-based reference model of the checker's rules.
`timescale 1ns/1ps
module tb_lane_tol_checker;
    localparam int unsigned LW    = 8;
    localparam int unsigned NL    = 16;
    localparam int unsigned DW    = LW * NL;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned CW    = 16;
    localparam int MODV = 1 << LW;
    localparam int CMAX = (1 << CW) - 1;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [LW-1:0] tol = '0;
    logic          wrap_mode = 1'b0;
    logic [CW-1:0] exp_total = '0;
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_ready;
    logic          wt_en = 1'b0;
    logic [AW-1:0] wt_addr = '0;
    logic [DW-1:0] wt_data = '0;
    logic          mismatch;
    logic [NL-1:0] mismatch_lanes;
    logic [CW-1:0] check_count;
    logic [CW-1:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic          first_err_vld;
    logic          underflow;
    logic          done;

    lane_tol_checker #(
        .LANE_W(LW), .LANES(NL), .EXP_DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .tol(tol), .wrap_mode(wrap_mode),
        .exp_total(exp_total), .exp_valid(exp_valid), .exp_data(exp_data),
        .exp_ready(exp_ready), .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .mismatch(mismatch), .mismatch_lanes(mismatch_lanes), .check_count(check_count),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_vld(first_err_vld), .underflow(underflow), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    typedef struct {
        int            due;
        logic [DW-1:0] e;
        logic [DW-1:0] c;
        logic [AW-1:0] addr;
    } pend_t;

    logic [DW-1:0] exp_q[$];
    pend_t         pend[$];
    int            cyc;
    int            m_state, m_tol, m_total, m_issued, m_chk, m_err;
    bit            m_mode, m_fev, m_unf, m_mm, m_rdy;
    logic [AW-1:0] m_fea;
    logic [NL-1:0] m_mml;

    bit            seen_mm;
    logic [NL-1:0] seen_lanes;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NL-1:0] ref_mask(input logic [DW-1:0] e, input logic [DW-1:0] c,
                                               input int t, input bit m);
        logic [NL-1:0] r;
        int ev, cv, d;
        r = '0;
        for (int i = 0; i < int'(NL); i++) begin
            ev = int'(e[i*LW +: LW]);
            cv = int'(c[i*LW +: LW]);
            if (m) begin
                d = (cv - ev + MODV) % MODV;
                if (MODV - d < d) d = MODV - d;
            end else begin
                d = (cv > ev) ? cv - ev : ev - cv;
            end
            r[i] = (d > t);
        end
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        m_state = M_IDLE; m_tol = 0; m_mode = 0; m_total = 0; m_issued = 0;
        m_chk = 0; m_err = 0; m_fev = 0; m_fea = '0; m_unf = 0;
        m_mm = 0; m_mml = '0; m_rdy = 1;
    endtask

    task automatic model_edge();
        pend_t pr;
        bit acc, dopop, dopush;
        cyc++;
        m_mm = 0;
        m_mml = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            pr = pend.pop_front();
            m_mml = ref_mask(pr.e, pr.c, m_tol, m_mode);
            m_mm = (m_mml != '0);
            if (m_chk < CMAX) m_chk++;
            if (m_mm) begin
                if (m_err < CMAX) m_err++;
                if (!m_fev) begin m_fev = 1; m_fea = pr.addr; end
            end
        end
        acc    = (m_state == M_RUN) && wt_en && (m_total == 0 || m_issued < m_total);
        dopop  = acc && exp_q.size() > 0;
        dopush = exp_valid && exp_q.size() < int'(DEPTH);
        if (acc && !dopop) m_unf = 1;
        if (dopop) begin
            pr.due = cyc + 1; pr.e = exp_q.pop_front(); pr.c = wt_data; pr.addr = wt_addr;
            pend.push_back(pr);
            if (m_issued < CMAX) m_issued++;
        end
        if (dopush) exp_q.push_back(exp_data);
        if (m_state == M_RUN && m_total != 0 && m_chk == m_total) m_state = M_DONE;
        if (enable) begin
            m_state = M_RUN; m_tol = int'(tol); m_mode = wrap_mode; m_total = int'(exp_total);
            m_issued = 0; m_chk = 0; m_err = 0; m_fev = 0; m_fea = '0; m_unf = 0;
            m_mm = 0; m_mml = '0;
        end
        m_rdy = exp_q.size() < int'(DEPTH);
    endtask

    task automatic compare_all();
        chk("exp_ready", 64'(exp_ready), 64'(m_rdy));
        chk("mismatch", 64'(mismatch), 64'(m_mm));
        chk("mismatch_lanes", 64'(mismatch_lanes), 64'(m_mml));
        chk("check_count", 64'(check_count), 64'(m_chk));
        chk("err_count", 64'(err_count), 64'(m_err));
        chk("first_err_addr", 64'(first_err_addr), 64'(m_fea));
        chk("first_err_vld", 64'(first_err_vld), 64'(m_fev));
        chk("underflow", 64'(underflow), 64'(m_unf));
        chk("done", 64'(done), 64'(m_state == M_DONE));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        if (mismatch) begin seen_mm = 1; seen_lanes = seen_lanes | mismatch_lanes; end
    endtask

    task automatic clear_seen();
        seen_mm = 0;
        seen_lanes = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic start(input int t, input bit m, input int total);
        tol = LW'(t); wrap_mode = m; exp_total = CW'(total); enable = 1'b1;
        cycle();
        enable = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        exp_data = d; exp_valid = 1'b1;
        cycle();
        exp_valid = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wt_addr = a; wt_data = d; wt_en = 1'b1;
        cycle();
        wt_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        for (int i = 0; i < int'(NL); i++) r[i*LW +: LW] = LW'($urandom);
        return r;
    endfunction

    // Lanes moved by up to +/-maxd; clamp keeps values in range, otherwise they wrap
    function automatic logic [DW-1:0] near(input logic [DW-1:0] b, input int maxd, input bit clamp);
        logic [DW-1:0] r;
        int v;
        for (int i = 0; i < int'(NL); i++) begin
            v = int'(b[i*LW +: LW]) + int'($urandom_range(0, 2 * maxd)) - maxd;
            if (clamp) begin
                if (v < 0) v = 0;
                if (v > MODV - 1) v = MODV - 1;
            end else begin
                v = (v + MODV) % MODV;
            end
            r[i*LW +: LW] = LW'(v);
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d4 [4];
        logic [DW-1:0] d17 [17];
        logic [DW-1:0] b, c;
        cyc = 0;
        clear_seen();
        model_reset();

        // Reset state
        @(negedge clk);
        compare_all();
        chk("rst_exp_ready", 64'(exp_ready), 64'd1);
        chk("rst_check_count", 64'(check_count), 64'd0);
        reset = 1'b1;
        idle(2);

        // 1: matching beats within tol=1
        start(1, 0, 0);
        for (int k = 0; k < 4; k++) begin d4[k] = rand_beat(); push(d4[k]); end
        clear_seen();
        for (int k = 0; k < 4; k++) write(AW'(16'h0100 + k), near(d4[k], 1, 1));
        idle(2);
        chk("t1_no_mismatch", 64'(seen_mm), 64'd0);
        chk("t1_check_count", 64'(check_count), 64'd4);
        chk("t1_err_count", 64'(err_count), 64'd0);

        // 2: beat 3 lane 5 off by two
        start(1, 0, 0);
        for (int k = 0; k < 4; k++) d4[k] = rand_beat();
        d4[2][5*LW +: LW] = 8'h40;
        for (int k = 0; k < 4; k++) push(d4[k]);
        clear_seen();
        for (int k = 0; k < 4; k++) begin
            b = d4[k];
            if (k == 2) b[5*LW +: LW] = 8'h42;
            write(AW'(16'h0200 + k), b);
        end
        idle(2);
        chk("t2_lanes", 64'(seen_lanes), 64'h0020);
        chk("t2_err_count", 64'(err_count), 64'd1);
        chk("t2_first_err_addr", 64'(first_err_addr), 64'h0202);
        chk("t2_first_err_vld", 64'(first_err_vld), 64'd1);

        // 3: 00 vs FF under both distance modes
        b = {NL{8'h10}};
        b[LW-1:0] = 8'h00;
        c = b;
        c[LW-1:0] = 8'hFF;
        start(1, 0, 0);
        push(b);
        clear_seen();
        write(16'h0300, c);
        idle(2);
        chk("t3_mode0_lanes", 64'(seen_lanes), 64'h0001);
        start(1, 1, 0);
        push(b);
        clear_seen();
        write(16'h0301, c);
        idle(2);
        chk("t3_mode1_mismatch", 64'(seen_mm), 64'd0);
        chk("t3_mode1_count", 64'(check_count), 64'd1);

        // 4: exp_total=3 stops after the third beat
        start(1, 0, 3);
        for (int k = 0; k < 3; k++) begin d4[k] = rand_beat(); push(d4[k]); end
        for (int k = 0; k < 5; k++) write(AW'(16'h0400 + k), (k < 3) ? d4[k] : rand_beat());
        idle(2);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_check_count", 64'(check_count), 64'd3);
        chk("t4_underflow", 64'(underflow), 64'd0);

        // 5: underflow on empty FIFO, then fill to full and overflow by one
        start(0, 0, 0);
        write(16'h0500, rand_beat());
        write(16'h0501, rand_beat());
        idle(2);
        chk("t5_underflow", 64'(underflow), 64'd1);
        chk("t5_no_compare", 64'(check_count), 64'd0);
        for (int k = 0; k < 17; k++) begin
            d17[k] = rand_beat();
            push(d17[k]);
            if (k == 15) chk("t5_ready_full", 64'(exp_ready), 64'd0);
        end
        for (int k = 0; k < 16; k++) write(AW'(16'h0510 + k), d17[k]);
        write(16'h0520, d17[16]);
        idle(2);
        chk("t5_check_count", 64'(check_count), 64'd16);
        chk("t5_err_count", 64'(err_count), 64'd0);
        chk("t5_ready_again", 64'(exp_ready), 64'd1);

        // Random traffic, occasional restarts with new settings
        start(int'($urandom_range(0, 3)), 1'($urandom), 0);
        for (int n = 0; n < 400; n++) begin
            exp_valid = ($urandom % 10) < 6;
            exp_data  = rand_beat();
            wt_en     = 1'($urandom);
            wt_addr   = AW'($urandom);
            wt_data   = (exp_q.size() > 0) ? near(exp_q[0], 4, 0) : rand_beat();
            if ($urandom % 60 == 0) begin
                enable    = 1'b1;
                tol       = LW'($urandom_range(0, 3));
                wrap_mode = 1'($urandom);
                exp_total = ($urandom % 3 == 0) ? CW'($urandom_range(1, 12)) : '0;
            end
            cycle();
            enable = 1'b0;
        end
        exp_valid = 1'b0;
        wt_en = 1'b0;
        idle(3);

        // 6: reset mid-run with beats in flight
        start(1, 0, 0);
        idle(2);
        while (exp_q.size() > 0) write(16'h0600, exp_q[0]);
        idle(2);
        for (int k = 0; k < 3; k++) begin d4[k] = rand_beat(); push(d4[k]); end
        write(16'h0610, near(d4[0], 3, 1));
        write(16'h0611, near(d4[1], 3, 1));
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all();
        chk("t6_mismatch", 64'(mismatch), 64'd0);
        chk("t6_check_count", 64'(check_count), 64'd0);
        chk("t6_exp_ready", 64'(exp_ready), 64'd1);
        @(negedge clk);
        compare_all();
        reset = 1'b1;
        idle(2);
        write(16'h0620, rand_beat());
        start(1, 0, 0);
        write(16'h0621, rand_beat());
        idle(2);
        chk("t6_fifo_empty_underflow", 64'(underflow), 64'd1);
        chk("t6_after_count", 64'(check_count), 64'd0);
        chk("t6_not_done", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
